// File: rtl/rggen_apb_request_bridge_if.sv
// Request/response stream and APB4 bundle for rggen_apb_request_bridge.
// The slave modport is the bridge's own view (it accepts requests and drives APB);
// the master modport is the surrounding environment's view.
interface rggen_apb_request_bridge_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     i_req_valid;
  logic                     o_req_ready;
  logic                     i_req_write;
  logic [ADDRESS_WIDTH-1:0] i_req_address;
  logic [BUS_WIDTH-1:0]     i_req_data;
  logic [BUS_WIDTH/8-1:0]   i_req_strobe;
  logic                     o_rsp_valid;
  logic                     i_rsp_ready;
  logic [BUS_WIDTH-1:0]     o_rsp_data;
  logic                     o_rsp_error;
  logic                     o_rsp_timeout;
  logic                     o_psel;
  logic                     o_penable;
  logic [ADDRESS_WIDTH-1:0] o_paddr;
  logic                     o_pwrite;
  logic [BUS_WIDTH-1:0]     o_pwdata;
  logic [BUS_WIDTH/8-1:0]   o_pstrb;
  logic                     i_pready;
  logic [BUS_WIDTH-1:0]     i_prdata;
  logic                     i_pslverr;

  modport slave (
    input  i_req_valid, i_req_write, i_req_address, i_req_data, i_req_strobe,
    input  i_rsp_ready, i_pready, i_prdata, i_pslverr,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error, o_rsp_timeout,
    output o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb
  );

  modport master (
    output i_req_valid, i_req_write, i_req_address, i_req_data, i_req_strobe,
    output i_rsp_ready, i_pready, i_prdata, i_pslverr,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_error, o_rsp_timeout,
    input  o_psel, o_penable, o_paddr, o_pwrite, o_pwdata, o_pstrb
  );
endinterface

// File: rtl/rggen_apb_request_bridge.sv
// rggen_apb_request_bridge: converts a valid/ready request stream into single
// outstanding APB4 transfers and returns one response per request.
// Optional access timeout: define RGGEN_APB_REQUEST_BRIDGE_TIMEOUT_EN.
//
// Handshake semantics (request and response streams alike): a beat transfers on
// a rising clock edge where valid && ready are both 1. The producer holds valid
// and its payload stable until that edge; ready never depends combinationally
// on valid (both ready and valid outputs here are registered).
module rggen_apb_request_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  rggen_apb_request_bridge_if.slave        bus,
  output logic [1:0]                       o_dbg_state
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    RESPONSE = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     req_ready_q;
  logic                     psel_q;
  logic                     penable_q;
  logic [ADDRESS_WIDTH-1:0] paddr_q;
  logic                     pwrite_q;
  logic [BUS_WIDTH-1:0]     pwdata_q;
  logic [STRB_WIDTH-1:0]    pstrb_q;
  logic                     rsp_valid_q;
  logic [BUS_WIDTH-1:0]     rsp_data_q;
  logic                     rsp_error_q;
  logic                     rsp_timeout_q;

  // Next values for captured request fields and the completion payload.
  logic [ADDRESS_WIDTH-1:0] paddr_d;
  logic [BUS_WIDTH-1:0]     pwdata_d;
  logic [STRB_WIDTH-1:0]    pstrb_d;
  logic [BUS_WIDTH-1:0]     rsp_data_d;
  logic                     timeout_expire_d;

  // Paddr is bus-aligned; reads carry no write data or strobes.
  assign paddr_d    = bus.i_req_address & ADDR_MASK;
  assign pwdata_d   = bus.i_req_write ? bus.i_req_data   : '0;
  assign pstrb_d    = bus.i_req_write ? bus.i_req_strobe : '0;
  // Read data is only returned for error-free reads.
  assign rsp_data_d = (!pwrite_q && !bus.i_pslverr) ? bus.i_prdata : '0;

`ifdef RGGEN_APB_REQUEST_BRIDGE_TIMEOUT_EN
  localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_WIDTH-1:0] wait_q;

  // Expiry is the ACCESS cycle that would bring the count to TIMEOUT_CYCLES.
  assign timeout_expire_d = (wait_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared while in SETUP (entry to ACCESS), counts stalled ACCESS cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_q <= '0;
    end else if (state_q == SETUP) begin
      wait_q <= '0;
    end else if (state_q == ACCESS && !bus.i_pready) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign timeout_expire_d = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Transfer FSM; every bus and response output is a register driven here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_req_valid && req_ready_q) begin
            state_q     <= SETUP;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            paddr_q     <= paddr_d;
            pwrite_q    <= bus.i_req_write;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.i_pready) begin
            state_q       <= RESPONSE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= bus.i_pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (timeout_expire_d) begin
            state_q       <= RESPONSE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        RESPONSE: begin
          if (bus.i_rsp_ready) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready   = req_ready_q;
  assign bus.o_psel        = psel_q;
  assign bus.o_penable     = penable_q;
  assign bus.o_paddr       = paddr_q;
  assign bus.o_pwrite      = pwrite_q;
  assign bus.o_pwdata      = pwdata_q;
  assign bus.o_pstrb       = pstrb_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_error   = rsp_error_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign o_dbg_state       = state_q;
endmodule

// File: tb/tb_rggen_apb_request_bridge.sv
// Testbench for rggen_apb_request_bridge: drives requests, models the APB slave
// inline, and scores every response against an expected queue.
module tb_rggen_apb_request_bridge;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TC = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;
  int cyc;
  int accept_cyc;
  int hs_cyc;
  logic [BW+1:0] exp_q[$];

  rggen_apb_request_bridge_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();

  rggen_apb_request_bridge #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus_if),
    .o_dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.i_req_valid   = 1'b0;
    bus_if.i_req_write   = 1'b0;
    bus_if.i_req_address = '0;
    bus_if.i_req_data    = '0;
    bus_if.i_req_strobe  = '0;
    bus_if.i_rsp_ready   = 1'b0;
    bus_if.i_pready      = 1'b0;
    bus_if.i_prdata      = '0;
    bus_if.i_pslverr     = 1'b0;
  endtask

  // One complete transfer. waits = stalled ACCESS cycles before pready (>= TC means never
  // in the timeout build). hold = extra cycles with rsp_ready low. pend = keep the request
  // valid during the hold so the next identical call is accepted right after the handshake.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                          input logic [SW-1:0] strb, input int waits, input logic [BW-1:0] rdata,
                          input logic slverr, input int hold, input bit pend);
    logic [BW+1:0] exp_rsp;
    logic [BW+1:0] got;
    logic [AW-1:0] exp_paddr;
    int  exp_acc;
    int  n_acc;
    int  lat;
    bit  timed_out;
    bit  done;
    timed_out = 1'b0;
`ifdef RGGEN_APB_REQUEST_BRIDGE_TIMEOUT_EN
    if (waits >= TC) timed_out = 1'b1;
`endif
    exp_acc = timed_out ? TC : waits + 1;
    if (timed_out) exp_rsp = {1'b1, 1'b1, {BW{1'b0}}};
    else           exp_rsp = {1'b0, slverr, (!wr && !slverr) ? rdata : {BW{1'b0}}};
    exp_q.push_back(exp_rsp);
    exp_paddr = {addr[AW-1:2], 2'b00};

    bus_if.i_req_valid   = 1'b1;
    bus_if.i_req_write   = wr;
    bus_if.i_req_address = addr;
    bus_if.i_req_data    = wdata;
    bus_if.i_req_strobe  = strb;
    bus_if.i_rsp_ready   = (hold == 0);
    @(negedge clk);
    check("idle_req_ready", bus_if.o_req_ready, 1);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    bus_if.i_req_valid = 1'b0;

    @(negedge clk);
    check("setup_phase", {bus_if.o_psel, bus_if.o_penable}, 2'b10);
    check("setup_state", dbg_state, 2'd1);
    check("setup_paddr", bus_if.o_paddr, exp_paddr);
    check("setup_pwrite", bus_if.o_pwrite, wr);
    check("setup_pwdata", bus_if.o_pwdata, wr ? wdata : '0);
    check("setup_pstrb", bus_if.o_pstrb, wr ? strb : '0);

    n_acc = 0;
    lat   = 1;
    done  = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      lat++;
      if (bus_if.o_rsp_valid) begin
        done = 1'b1;
      end else begin
        n_acc++;
        check("access_phase", {bus_if.o_psel, bus_if.o_penable}, 2'b11);
        check("access_paddr_stable", bus_if.o_paddr, exp_paddr);
        check("access_pwdata_stable", bus_if.o_pwdata, wr ? wdata : '0);
        if (n_acc - 1 == waits) begin
          bus_if.i_pready  = 1'b1;
          bus_if.i_prdata  = rdata;
          bus_if.i_pslverr = slverr;
        end else begin
          bus_if.i_pready  = 1'b0;
          bus_if.i_prdata  = $urandom;
          bus_if.i_pslverr = 1'($urandom_range(0, 1));
        end
      end
    end
    bus_if.i_pready  = 1'b0;
    bus_if.i_pslverr = 1'b0;
    if (!done) begin
      check("rsp_wait_bound", 0, 1);
      void'(exp_q.pop_front());
      return;
    end

    check("rsp_latency", lat, exp_acc + 2);
    check("access_cycles", n_acc, exp_acc);
    check("rsp_apb_idle", {bus_if.o_psel, bus_if.o_penable}, 2'b00);
    check("rsp_req_ready", bus_if.o_req_ready, 0);
    check("rsp_state", dbg_state, 2'd3);
    got = {bus_if.o_rsp_timeout, bus_if.o_rsp_error, bus_if.o_rsp_data};
    check("rsp_payload", got, exp_q.pop_front());

    if (hold > 0) begin
      if (pend) bus_if.i_req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_rsp_valid", bus_if.o_rsp_valid, 1);
        check("hold_rsp_stable", {bus_if.o_rsp_timeout, bus_if.o_rsp_error, bus_if.o_rsp_data}, got);
        check("hold_req_ready", bus_if.o_req_ready, 0);
      end
      bus_if.i_rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    bus_if.i_rsp_ready = 1'b0;
    check("post_hs_rsp_valid", bus_if.o_rsp_valid, 0);
    check("post_hs_req_ready", bus_if.o_req_ready, 1);
  endtask

  initial begin
    int a_cyc;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    idle_inputs();

    // Reset state
    rst = 1'b1;
    #2;
    check("rst_req_ready", bus_if.o_req_ready, 1);
    check("rst_apb", {bus_if.o_psel, bus_if.o_penable, bus_if.o_pwrite}, 3'b000);
    check("rst_paddr", bus_if.o_paddr, 0);
    check("rst_pwdata_pstrb", {bus_if.o_pwdata, bus_if.o_pstrb}, 0);
    check("rst_rsp", {bus_if.o_rsp_valid, bus_if.o_rsp_timeout, bus_if.o_rsp_error, bus_if.o_rsp_data}, 0);
    check("rst_state", dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait write; prdata on the bus must not leak into a write response
    run_xfer(1'b1, 8'h04, 32'hA5A5_0F0F, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // Read with 3 wait states and an unaligned address
    run_xfer(1'b0, 8'h07, 32'hFFFF_FFFF, 4'hF, 3, 32'h0000_0F0F, 1'b0, 0, 1'b0);
    // Read with slave error
    run_xfer(1'b0, 8'h10, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b1, 0, 1'b0);
    // Partial-strobe write with unaligned address
    run_xfer(1'b1, 8'h33, 32'h0102_0304, 4'h5, 2, 32'h0, 1'b0, 0, 1'b0);

    // Back-to-back throughput: one transfer per 4 cycles
    run_xfer(1'b1, 8'h20, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
    a_cyc = accept_cyc;
    run_xfer(1'b0, 8'h24, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    check("b2b_spacing", accept_cyc - a_cyc, 4);

    // Response back-pressure with a pending request
    run_xfer(1'b0, 8'h08, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0, 5, 1'b1);
    a_cyc = hs_cyc;
    run_xfer(1'b0, 8'h08, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0, 0, 1'b0);
    check("pending_accept_delay", accept_cyc - a_cyc, 1);

`ifdef RGGEN_APB_REQUEST_BRIDGE_TIMEOUT_EN
    // pready never arrives: abort after TC ACCESS cycles
    run_xfer(1'b0, 8'h40, 32'h0, 4'h0, 1000, 32'h9999_9999, 1'b0, 0, 1'b0);
    // pready in the expiry cycle completes normally
    run_xfer(1'b0, 8'h44, 32'h0, 4'h0, TC - 1, 32'h7777_1234, 1'b0, 0, 1'b0);
`endif

    // Randomized transfers
    for (int r = 0; r < 6; r++) begin
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
               int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), 1'b0);
    end

    // Asynchronous reset during ACCESS drops the transfer
    bus_if.i_req_valid   = 1'b1;
    bus_if.i_req_write   = 1'b0;
    bus_if.i_req_address = 8'h50;
    bus_if.i_rsp_ready   = 1'b1;
    @(posedge clk);
    #1 bus_if.i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_access", {bus_if.o_psel, bus_if.o_penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_apb", {bus_if.o_psel, bus_if.o_penable}, 2'b00);
    check("async_rst_rsp_valid", bus_if.o_rsp_valid, 0);
    check("async_rst_req_ready", bus_if.o_req_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", bus_if.o_rsp_valid, 0);
      check("post_rst_req_ready", bus_if.o_req_ready, 1);
    end
    @(posedge clk);
    #1;
    run_xfer(1'b1, 8'h60, 32'hBEEF_0001, 4'h3, 1, 32'h0, 1'b0, 0, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
